// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
// Serial bit-pattern detector for framing/sync-word spotting. A qualified
// one-bit stream is shifted into a history register and compared against a
// runtime-programmable, optionally masked pattern of PAT_LEN bits. Matches
// produce a one-cycle registered pulse and bump a saturating counter.
// Overlapping and non-overlapping match modes are selectable at runtime.

module seq_pattern_detector #(
  parameter int unsigned        PAT_LEN     = 6,
  parameter logic [PAT_LEN-1:0] PATTERN     = 6'b110101,
  parameter logic               OVERLAP_DEF = 1'b1,
  parameter int unsigned        CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [PAT_LEN-1:0] cfg_mask,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  // The fill counter must be able to hold the value PAT_LEN itself.
  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [FILL_W-1:0]  FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [PAT_LEN-1:0] PAT_ZERO  = {PAT_LEN{1'b0}};
  localparam logic [PAT_LEN-1:0] PAT_ONES  = {PAT_LEN{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // Architectural state.
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-1:0] r_msk;
  logic               r_ovl;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;

  // Combinational next-state values.
  logic               w_accept;
  logic [PAT_LEN-1:0] w_hist_shift;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_window_full;
  logic               w_compare_ok;
  logic               w_hit;
  logic [PAT_LEN-1:0] w_hist_d;
  logic [FILL_W-1:0]  w_fill_d;
  logic [PAT_LEN-1:0] w_pat_d;
  logic [PAT_LEN-1:0] w_msk_d;
  logic               w_ovl_d;
  logic               w_match_d;
  logic [CNT_W-1:0]   w_cnt_d;

  // A bit is consumed only when valid and not shadowed by a config load.
  assign w_accept = in_valid & ~cfg_load;

  // Candidate window after shifting the incoming bit in at the LSB.
  assign w_hist_shift = {r_hist[PAT_LEN-2:0], in};

  // Saturating fill count: never exceeds PAT_LEN.
  always_comb begin
    w_fill_inc = r_fill;
    if (r_fill == FILL_FULL) begin
      w_fill_inc = FILL_FULL;
    end else begin
      w_fill_inc = r_fill + FILL_ONE;
    end
  end

  // Masked comparison; bits with mask 0 are don't-care, so an all-zero mask
  // hits on every accepted bit once the window is full.
  assign w_window_full = (w_fill_inc == FILL_FULL);
  assign w_compare_ok  = (((w_hist_shift ^ r_pat) & r_msk) == PAT_ZERO);
  assign w_hit         = w_accept & w_window_full & w_compare_ok;

  // Next-state for window, configuration and match pulse.
  always_comb begin
    w_hist_d  = r_hist;
    w_fill_d  = r_fill;
    w_pat_d   = r_pat;
    w_msk_d   = r_msk;
    w_ovl_d   = r_ovl;
    w_match_d = 1'b0;
    if (cfg_load) begin
      // New configuration restarts the window; any same-cycle bit is dropped.
      w_pat_d  = cfg_pattern;
      w_msk_d  = cfg_mask;
      w_ovl_d  = cfg_overlap;
      w_hist_d = PAT_ZERO;
      w_fill_d = FILL_ZERO;
    end else if (w_hit) begin
      w_match_d = 1'b1;
      w_hist_d  = w_hist_shift;
      if (r_ovl) begin
        // Keep the full window so the very next bit can complete a match.
        w_fill_d = FILL_FULL;
      end else begin
        // Demand PAT_LEN fresh bits before the next match can occur.
        w_fill_d = FILL_ZERO;
      end
    end else if (w_accept) begin
      w_hist_d = w_hist_shift;
      w_fill_d = w_fill_inc;
    end else begin
      w_hist_d = r_hist;
      w_fill_d = r_fill;
    end
  end

  // Match counter: clear wins over hold, but a coincident hit counts as one.
  always_comb begin
    w_cnt_d = r_cnt;
    if (cnt_clr) begin
      if (w_hit) begin
        w_cnt_d = CNT_ONE;
      end else begin
        w_cnt_d = CNT_ZERO;
      end
    end else if (w_hit) begin
      if (r_cnt == CNT_MAX) begin
        w_cnt_d = CNT_MAX;
      end else begin
        w_cnt_d = r_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_d = r_cnt;
    end
  end

  // Window and fill state; reset discards any partial pattern.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= PAT_ZERO;
      r_fill <= FILL_ZERO;
    end else begin
      r_hist <= w_hist_d;
      r_fill <= w_fill_d;
    end
  end

  // Active configuration; reset restores the build-time pattern and mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pat <= PATTERN;
      r_msk <= PAT_ONES;
      r_ovl <= OVERLAP_DEF;
    end else begin
      r_pat <= w_pat_d;
      r_msk <= w_msk_d;
      r_ovl <= w_ovl_d;
    end
  end

  // Registered outputs: match pulse and saturating counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_match <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_match <= w_match_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign match     = r_match;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (PAT_LEN=6, CNT_W=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge that registers them.

module tb_seq_pattern_detector;

  localparam int PAT_LEN = 6;
  localparam int CNT_W   = 3;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic               s_in;
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic [PAT_LEN-1:0] cfg_mask;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;

  int n_checks;
  int n_errors;

  seq_pattern_detector #(
    .PAT_LEN    (PAT_LEN),
    .PATTERN    (6'b110101),
    .OVERLAP_DEF(1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in         (s_in),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_cnt  (match_cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feed n bits MSB first; exp holds the expected match after each bit.
  // With gap=1 an idle cycle follows every bit and match must be low there.
  task automatic feed(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] exp, input bit gap);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      s_in     = bits[n-1-k];
      @(posedge clk);
      #1;
      chk_val($sformatf("%s_b%0d", tag, k + 1), {31'd0, match}, {31'd0, exp[n-1-k]});
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        s_in     = 1'b1;
        @(posedge clk);
        #1;
        chk_val($sformatf("%s_gap%0d", tag, k + 1), {31'd0, match}, 32'd0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    s_in     = 1'b0;
  endtask

  // Load configuration while presenting a valid 1 that must be dropped.
  task automatic do_cfg(input string tag, input logic [PAT_LEN-1:0] pat,
                        input logic [PAT_LEN-1:0] msk, input logic ovl);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    s_in        = 1'b1;
    @(posedge clk);
    #1;
    chk_val({tag, "_cfg_match"}, {31'd0, match}, 32'd0);
    @(negedge clk);
    cfg_load = 1'b0;
    in_valid = 1'b0;
    s_in     = 1'b0;
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    chk_val({tag, "_clr_cnt"}, {29'd0, match_cnt}, 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rstn        = 1'b0;
    in_valid    = 1'b0;
    s_in        = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 6'b000000;
    cfg_mask    = 6'b111111;
    cfg_overlap = 1'b1;
    cnt_clr     = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_match", {31'd0, match}, 32'd0);
    chk_val("rst_cnt", {29'd0, match_cnt}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Overlap mode with defaults: hits after bits 6 and 11.
    feed("ovl", 32'b11010110101, 11, 32'b00000100001, 1'b0);
    chk_val("ovl_cnt", {29'd0, match_cnt}, 32'd2);
    do_clr("ovl");

    // Non-overlap mode: only the first window matches.
    do_cfg("novl", 6'b110101, 6'b111111, 1'b0);
    feed("novl", 32'b11010110101, 11, 32'b00000100000, 1'b0);
    chk_val("novl_cnt", {29'd0, match_cnt}, 32'd1);
    do_clr("novl");

    // Masked pattern: only the upper four bits (1101) are compared.
    do_cfg("msk", 6'b110100, 6'b111100, 1'b0);
    feed("msk_hit", 32'b110111, 6, 32'b000001, 1'b0);
    feed("msk_miss", 32'b111100, 6, 32'b000000, 1'b0);
    chk_val("msk_cnt", {29'd0, match_cnt}, 32'd1);

    // Valid gaps: match only on the 6th valid bit.
    do_cfg("gap", 6'b110101, 6'b111111, 1'b1);
    do_clr("gap");
    feed("gap", 32'b110101, 6, 32'b000001, 1'b1);
    chk_val("gap_cnt", {29'd0, match_cnt}, 32'd1);

    // Mid-stream reset after loading a foreign pattern: the partial window
    // and the runtime config are both discarded.
    do_cfg("rst", 6'b000000, 6'b111111, 1'b0);
    feed("rst_pre", 32'b11010, 5, 32'b00000, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #2;
    chk_val("rst_mid_match", {31'd0, match}, 32'd0);
    chk_val("rst_mid_cnt", {29'd0, match_cnt}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    feed("rst_post1", 32'b1, 1, 32'b0, 1'b0);
    feed("rst_post2", 32'b10101, 5, 32'b00001, 1'b0);
    chk_val("rst_post_cnt", {29'd0, match_cnt}, 32'd1);

    // Counter saturation: mask 0 makes every bit after the 5th a hit.
    do_clr("sat");
    do_cfg("sat", 6'b000000, 6'b000000, 1'b1);
    feed("sat", 32'b0, 14, 32'b00000111111111, 1'b0);
    chk_val("sat_cnt", {29'd0, match_cnt}, 32'd7);
    feed("sat_hold", 32'b0, 2, 32'b11, 1'b0);
    chk_val("sat_hold_cnt", {29'd0, match_cnt}, 32'd7);

    // cnt_clr coincident with a hit: count restarts at 1, pulse still fires.
    @(negedge clk);
    in_valid = 1'b1;
    s_in     = 1'b1;
    cnt_clr  = 1'b1;
    @(posedge clk);
    #1;
    chk_val("clrhit_match", {31'd0, match}, 32'd1);
    chk_val("clrhit_cnt", {29'd0, match_cnt}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_val("clronly_match", {31'd0, match}, 32'd0);
    chk_val("clronly_cnt", {29'd0, match_cnt}, 32'd0);
    @(negedge clk);
    cnt_clr = 1'b0;

    // Config load mid-window: 1101 | load | 01 must not complete 110101.
    do_cfg("cl", 6'b110101, 6'b111111, 1'b1);
    feed("cl_pre", 32'b1101, 4, 32'b0000, 1'b0);
    do_cfg("cl_mid", 6'b110101, 6'b111111, 1'b1);
    feed("cl_01", 32'b01, 2, 32'b00, 1'b0);
    feed("cl_1101", 32'b1101, 4, 32'b0000, 1'b0);
    feed("cl_tail", 32'b01, 2, 32'b01, 1'b0);
    chk_val("cl_cnt", {29'd0, match_cnt}, 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
